// File: rtl/tx_byte_queue.sv
// Byte FIFO that paces bytes to uart_tx as one-cycle data_send strobes spaced BYTE_GAP clocks apart.
// Optional macro TXQ_DROP_CNT_EN enables the saturating overflow counter on drop_count.
module tx_byte_queue #(
    parameter int DEPTH    = 16,
    parameter int BYTE_GAP = 4340
) (
    input  logic                     clk_50M,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic [7:0]               data,
    output logic                     data_send,
    output logic [7:0]               drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(BYTE_GAP);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(BYTE_GAP - 1);

    typedef enum logic {IDLE, GAP} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
    logic [7:0]      mem [DEPTH];
    logic            issue;
    logic            wr_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign busy  = (state == GAP);

    // Issue decisions use the registered count, so a byte written into an empty queue waits one cycle.
    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        issue       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0 && !flush) begin
                    issue       = 1'b1;
                    state_nxt   = GAP;
                    gap_cnt_nxt = GAP_RELOAD;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    if (count != '0 && !flush) begin
                        issue       = 1'b1;
                        gap_cnt_nxt = GAP_RELOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A full queue still takes a write when the same edge issues, reusing the freed slot.
    assign wr_ok = wr_en && !flush && (!full || issue);

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data      <= 8'h00;
            data_send <= 1'b0;
        end else begin
            state     <= state_nxt;
            gap_cnt   <= gap_cnt_nxt;
            data_send <= issue;
            if (issue) begin
                data <= mem[rd_ptr];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (issue) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({wr_ok, issue})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (!reset && wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

`ifdef TXQ_DROP_CNT_EN
    logic drop;
    assign drop = wr_en && !flush && full && !issue;

    // Survives flush so overflow history is visible until the next reset.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            drop_count <= 8'h00;
        end else if (drop && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'h01;
        end
    end
`else
    assign drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_tx_byte_queue.sv
// Randomized and directed bench for tx_byte_queue against a queue/elapsed-time reference model.
// Built with DEPTH=4 and BYTE_GAP=8 so pacing scenarios stay short.
module tb_tx_byte_queue;

    localparam int DEPTH    = 4;
    localparam int BYTE_GAP = 8;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic          clk_50M = 1'b0;
    logic          reset   = 1'b1;
    logic          flush   = 1'b0;
    logic          wr_en   = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          busy;
    logic [7:0]    data;
    logic          data_send;
    logic [7:0]    drop_count;

    int checks = 0;
    int passed = 0;

    // Reference model: pending bytes, cycles since the last strobe, last strobed byte.
    logic [7:0] q[$];
    int         since   = BYTE_GAP;
    logic [7:0] m_data  = 8'h00;
    logic       m_send  = 1'b0;
    int         m_drops = 0;

    tx_byte_queue #(.DEPTH(DEPTH), .BYTE_GAP(BYTE_GAP)) dut (
        .clk_50M    (clk_50M),
        .reset      (reset),
        .flush      (flush),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .busy       (busy),
        .data       (data),
        .data_send  (data_send),
        .drop_count (drop_count)
    );

    always #5 clk_50M = ~clk_50M;

    function automatic logic [22:0] obs();
        return {data, data_send, busy, count, empty, full, drop_count};
    endfunction

    function automatic logic [22:0] expv();
        logic [CW-1:0] c;
        c = CW'(q.size());
        return {m_data, m_send, (since < BYTE_GAP), c, (q.size() == 0), (q.size() == DEPTH), 8'(m_drops)};
    endfunction

    task automatic model_edge(input bit r, input bit f, input bit we, input logic [7:0] wd);
        bit iss;
        bit was_full;
        if (r) begin
            q.delete();
            since   = BYTE_GAP;
            m_data  = 8'h00;
            m_send  = 1'b0;
            m_drops = 0;
        end else begin
            was_full = (q.size() == DEPTH);
            iss      = !f && (q.size() != 0) && (since >= BYTE_GAP - 1);
            m_send   = iss;
            if (iss) begin
                m_data = q.pop_front();
                since  = 0;
            end else if (since < BYTE_GAP) begin
                since++;
            end
            if (f) begin
                q.delete();
            end else if (we) begin
                if (!was_full || iss) begin
                    q.push_back(wd);
                end else begin
`ifdef TXQ_DROP_CNT_EN
                    if (m_drops < 255) m_drops++;
`endif
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit f, input bit we, input logic [7:0] wd);
        @(negedge clk_50M);
        reset   = r;
        flush   = f;
        wr_en   = we;
        wr_data = wd;
        @(posedge clk_50M);
        model_edge(r, f, we, wd);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 1'b1, 8'hEE);
        checks++;
        if (obs() !== {8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00})
            $display("FAIL reset_state got=%h want=%h", obs(), {8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00});
        else passed++;
        checks++;
        if (obs() !== expv()) $display("FAIL reset_model got=%h want=%h", obs(), expv());
        else passed++;
    endtask

    task automatic test_single();
        int busy_cycles = 0;
        step(1'b0, 1'b0, 1'b1, 8'h41);
        checks++;
        if ({data_send, count} !== {1'b0, 3'd1}) $display("FAIL single_accept got=%b want=%b", {data_send, count}, {1'b0, 3'd1});
        else passed++;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if ({data_send, data} !== 9'h141) $display("FAIL single_strobe got=%h want=%h", {data_send, data}, 9'h141);
        else passed++;
        if (busy) busy_cycles++;
        for (int i = 0; i < BYTE_GAP + 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            if (busy) busy_cycles++;
            checks++;
            if (obs() !== expv()) $display("FAIL single_cyc%0d got=%h want=%h", i, obs(), expv());
            else passed++;
        end
        checks++;
        if (busy_cycles !== BYTE_GAP) $display("FAIL single_busy_len got=%0d want=%0d", busy_cycles, BYTE_GAP);
        else passed++;
        checks++;
        if ({busy, empty} !== 2'b01) $display("FAIL single_idle got=%b want=01", {busy, empty});
        else passed++;
    endtask

    task automatic test_burst();
        int st[$];
        logic [7:0] sd[$];
        int peak = 0;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 50; i++) begin
            if (i < 5) step(1'b0, 1'b0, 1'b1, 8'(i + 1));
            else       step(1'b0, 1'b0, 1'b0, 8'h00);
            if (data_send) begin
                st.push_back(i);
                sd.push_back(data);
            end
            if (int'(count) > peak) peak = int'(count);
            checks++;
            if (obs() !== expv()) $display("FAIL burst_cyc%0d got=%h want=%h", i, obs(), expv());
            else passed++;
        end
        checks++;
        if (st.size() !== 5) $display("FAIL burst_strobes got=%0d want=5", st.size());
        else passed++;
        for (int k = 0; k < st.size(); k++) begin
            checks++;
            if (sd[k] !== 8'(k + 1)) $display("FAIL burst_order%0d got=%h want=%h", k, sd[k], 8'(k + 1));
            else passed++;
            if (k > 0) begin
                checks++;
                if (st[k] - st[k-1] !== BYTE_GAP) $display("FAIL burst_spacing%0d got=%0d want=%0d", k, st[k] - st[k-1], BYTE_GAP);
                else passed++;
            end
        end
        checks++;
        if (peak !== 4) $display("FAIL burst_peak got=%0d want=4", peak);
        else passed++;
    endtask

    task automatic test_overflow();
        int n = 0;
        int want_drops;
`ifdef TXQ_DROP_CNT_EN
        want_drops = 2;
`else
        want_drops = 0;
`endif
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 50; i++) begin
            if (i < 7) step(1'b0, 1'b0, 1'b1, 8'(8'h10 + i));
            else       step(1'b0, 1'b0, 1'b0, 8'h00);
            if (data_send) begin
                checks++;
                if (data !== 8'(8'h10 + n)) $display("FAIL ovf_data%0d got=%h want=%h", n, data, 8'(8'h10 + n));
                else passed++;
                n++;
            end
            checks++;
            if (obs() !== expv()) $display("FAIL ovf_cyc%0d got=%h want=%h", i, obs(), expv());
            else passed++;
        end
        checks++;
        if (n !== 5) $display("FAIL ovf_strobes got=%0d want=5", n);
        else passed++;
        checks++;
        if (int'(drop_count) !== want_drops) $display("FAIL ovf_drops got=%0d want=%0d", drop_count, want_drops);
        else passed++;
    endtask

    task automatic test_full_expiry();
        logic [7:0] drops_before;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h30 + i));
        checks++;
        if ({full, count} !== {1'b1, 3'd4}) $display("FAIL fexp_fill got=%b want=%b", {full, count}, {1'b1, 3'd4});
        else passed++;
        for (int i = 0; i < 2 * BYTE_GAP && since < BYTE_GAP - 1; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        drops_before = drop_count;
        step(1'b0, 1'b0, 1'b1, 8'hAA);
        checks++;
        if ({data_send, data, count, drop_count} !== {1'b1, 8'h31, 3'd4, drops_before})
            $display("FAIL fexp_same_edge got=%h want=%h", {data_send, data, count, drop_count}, {1'b1, 8'h31, 3'd4, drops_before});
        else passed++;
        checks++;
        if (obs() !== expv()) $display("FAIL fexp_model got=%h want=%h", obs(), expv());
        else passed++;
    endtask

    task automatic test_flush();
        int n = 0;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h21 + i));
        step(1'b0, 1'b1, 1'b1, 8'h99);
        checks++;
        if ({count, empty, data, busy} !== {3'd0, 1'b1, 8'h21, 1'b1})
            $display("FAIL flush_now got=%h want=%h", {count, empty, data, busy}, {3'd0, 1'b1, 8'h21, 1'b1});
        else passed++;
        for (int i = 0; i < 3 * BYTE_GAP; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            if (data_send) n++;
            checks++;
            if (obs() !== expv()) $display("FAIL flush_cyc%0d got=%h want=%h", i, obs(), expv());
            else passed++;
        end
        checks++;
        if ({n[3:0], data, busy} !== {4'd0, 8'h21, 1'b0}) $display("FAIL flush_after got=%h want=%h", {n[3:0], data, busy}, {4'd0, 8'h21, 1'b0});
        else passed++;
    endtask

    task automatic test_reset_mid_gap();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h50 + i));
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h7E);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if ({data_send, data, busy} !== {1'b1, 8'h7E, 1'b1}) $display("FAIL rstgap_strobe got=%h want=%h", {data_send, data, busy}, {1'b1, 8'h7E, 1'b1});
        else passed++;
        checks++;
        if (obs() !== expv()) $display("FAIL rstgap_model got=%h want=%h", obs(), expv());
        else passed++;
    endtask

    task automatic test_random();
        bit r, f, we;
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            f  = ($urandom_range(0, 79) == 0);
            we = ($urandom_range(0, 99) < ((i / 200) % 2 == 0 ? 70 : 12));
            step(r, f, we, 8'($urandom));
            checks++;
            if (obs() !== expv()) $display("FAIL random_cyc%0d got=%h want=%h", i, obs(), expv());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_expiry();
        test_flush();
        test_reset_mid_gap();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tx_byte_queue.md
# tx_byte_queue

Byte FIFO and pacing sequencer between `message_unit` (producer of status/fault message bytes) and `uart_tx` (consumer) on the `clk_50M` domain. It accepts bursts of message bytes at any rate and hands them to `uart_tx` one at a time, each as a one-cycle `data_send` strobe with stable `data`. Strobes are spaced by a fixed byte period so that no byte is overwritten while the transmitter is still shifting. This keeps multi-byte messages intact when several events fire close together (fault, block pick, run end).

## Interface
Parameters:
- `DEPTH`, 16: queue entries; power of two, ≥2.
- `BYTE_GAP`, 4340: clocks between successive `data_send` strobes. This is 10 bits × 434 clocks at 115200 baud from 50 MHz. Must be ≥2.

Ports:
- `clk_50M` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: synchronous; discards queued bytes.
- `wr_en` in 1: push `wr_data` this cycle.
- `wr_data` in 8: byte to enqueue.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `count` out $clog2(DEPTH)+1: entries held.
- `busy` out 1: inside a byte period (state GAP).
- `data` out 8: byte presented to `uart_tx`.
- `data_send` out 1: one-cycle strobe to `uart_tx`.
- `drop_count` out 8: overflowed writes; see Configuration.

## Operation
- Storage: circular buffer `mem[DEPTH]` addressed by wr_ptr and rd_ptr, each $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. `count` is a separate register.
- Write acceptance uses the registered `full`:
  - If `full` = 0, `wr_en` stores `wr_data` at wr_ptr and wr_ptr increments.
  - If `full` = 1, the write is accepted only if an issue happens in the same cycle; the slot freed by the issue is reused. Otherwise the byte is dropped and the queue is unchanged.
- Issue: `data` ← mem[rd_ptr], rd_ptr increments, `data_send` = 1 for exactly one cycle, gap_cnt ← BYTE_GAP−1.
- State machine with two states: IDLE and GAP.
  - IDLE: if count ≠ 0, issue and go to GAP. Otherwise stay in IDLE.
  - GAP: gap_cnt decrements each cycle. When gap_cnt == 0: if count ≠ 0, issue and stay in GAP (gap_cnt reloaded); otherwise go to IDLE.
- Write and issue in the same cycle: `count` is unchanged and both pointers advance.
- A write into an empty queue cannot be issued in the same cycle, because issue reads the registered count.
- `data` holds its last issued value until the next issue. It is never altered by writes.
- `flush`:
  - Sets wr_ptr = rd_ptr = 0 and count = 0.
  - Ignores `wr_en` in that cycle.
  - Does not abort the current GAP, so the byte already strobed still gets its full period.
  - `flush` together with a same-cycle issue condition suppresses the issue.
- Reset: all pointers, count, gap_cnt and drop_count ← 0; state ← IDLE. Outputs: `data` = 8'h00, `data_send` = 0, `busy` = 0, `empty` = 1, `full` = 0, `count` = 0.
- Reset mid-GAP: queued bytes are lost and the next accepted write is issued without waiting out the old period. Memory contents need not be cleared.
- Reset has priority over `flush`; `flush` has priority over `wr_en`.

## Timing
- Write accepted at edge n into an empty, idle queue → `data_send` high in the cycle following edge n+1, with `data` = that byte.
- Back-to-back strobes are exactly BYTE_GAP cycles apart (edge k to edge k+BYTE_GAP) while the queue is non-empty.
- If the queue empties, the next strobe comes at the later of:
  - one cycle after the write, or
  - the end of the current period.
- `busy` is high from the issue edge until the edge that returns to IDLE.
- `full`, `empty` and `count` are registered and reflect state after the edge.

## Configuration
- `TXQ_DROP_CNT_EN` defined:
  - `drop_count` increments on every dropped write (write with `full` = 1 and no same-cycle issue).
  - It saturates at 8'hFF.
  - It is cleared by `reset` only, not by `flush`.
- Not defined: `drop_count` is tied to 8'h00 and the counter logic is absent. Queue behaviour is identical either way.

## Test plan
- Reset then single write 8'h41 at edge n → `data_send` pulse after edge n+1, `data` = 8'h41, `busy` high for 4340 cycles, then `empty` = 1 and `busy` = 0.
- Burst of 5 bytes 8'h01..8'h05 on consecutive cycles (BYTE_GAP = 8 override) → 5 strobes exactly 8 cycles apart, in order; `count` peaks at 4.
- DEPTH = 4, BYTE_GAP = 8, 7 writes back-to-back → first write issued immediately, queue then fills to 4, remaining 2 writes dropped; `drop_count` = 2 with `TXQ_DROP_CNT_EN`, 0 without it; 5 bytes transmitted.
- Full queue with a write on the gap-expiry edge → issue and write both take effect; `count` stays 4 and `drop_count` is unchanged.
- `flush` asserted mid-GAP with 3 bytes queued → `count` = 0 next cycle, no further strobes after the current period; `data` keeps its last value.
- `reset` asserted mid-GAP with bytes queued, write 8'h7E one cycle after release → strobe with 8'h7E on the following cycle, not after the old period.
